// File: rtl/lsu_pkg.sv
// lsu_pkg: shared constants for the load/store unit.
// Holds the RV32I funct3 size codes, the FSM state encoding and the access-size
// decode helper used by the top level and the lane aligner.
package lsu_pkg;

  // RV32I funct3 codes for loads/stores
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CAP  = 3'd2,
    S_WR   = 3'd3,
    S_RESP = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_t;

  // Any code outside the supported table decodes to a full word.
  // Stores have no unsigned variants, so BU/HU are word stores.
  function automatic size_t decode_size(input logic is_store, input logic [2:0] f3);
    size_t s;
    s = SZ_W;
    case (f3)
      F3_B:    s = SZ_B;
      F3_H:    s = SZ_H;
      F3_W:    s = SZ_W;
      F3_BU:   s = is_store ? SZ_W : SZ_B;
      F3_HU:   s = is_store ? SZ_W : SZ_H;
      default: s = SZ_W;
    endcase
    return s;
  endfunction

  function automatic logic decode_unsigned(input logic is_store, input logic [2:0] f3);
    return !is_store && (f3 == F3_BU || f3 == F3_HU);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane extraction/extension for loads and
// byte/halfword lane merge for read-modify-write stores.
// Ports: size/is_unsigned/lane select the lane; rd_word -> load_val,
//        old_word + wdata -> merged (full-word write data).
module lsu_align
  import lsu_pkg::*;
#(
  parameter int Width = 32
) (
  input  logic [1:0]       size,
  input  logic             is_unsigned,
  input  logic [1:0]       lane,
  input  logic [Width-1:0] rd_word,
  input  logic [Width-1:0] old_word,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] load_val,
  output logic [Width-1:0] merged
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v   = rd_word[8*lane +: 8];
    half_v   = rd_word[16*lane[1] +: 16];
    load_val = rd_word;
    merged   = wdata;
    case (size)
      SZ_B: begin
        load_val = is_unsigned ? {{(Width-8){1'b0}}, byte_v}
                               : {{(Width-8){byte_v[7]}}, byte_v};
        merged                = old_word;
        merged[8*lane +: 8]   = wdata[7:0];
      end
      SZ_H: begin
        load_val = is_unsigned ? {{(Width-16){1'b0}}, half_v}
                               : {{(Width-16){half_v[15]}}, half_v};
        merged                    = old_word;
        merged[16*lane[1] +: 16]  = wdata[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store sequencer in front of a one-cycle-latency
// word memory. Ports: req_* CPU request, resp_valid/rdata/misaligned response,
// MemRead/MemWrite/Addr/WrData/ReadData memory side.
// Option: define LSU_MISALIGN_TRAP_EN to trap misaligned H/W accesses
// instead of silently aligning them.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int Width    = 32,
  parameter int AddrBits = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                is_store,
  input  logic [2:0]          funct3,
  input  logic [31:0]         addr,
  input  logic [Width-1:0]    wdata,
  output logic                resp_valid,
  output logic [Width-1:0]    rdata,
  output logic                misaligned,
  output logic                MemWrite,
  output logic                MemRead,
  output logic [AddrBits-1:0] Addr,
  output logic [Width-1:0]    WrData,
  input  logic [Width-1:0]    ReadData
);

  localparam int BA = AddrBits + 2;  // byte-address bits kept; the rest wrap away

  state_t           state, state_nx;
  size_t            req_size, size_q;
  logic             accept, trap_hit, uns_q, store_q;
  logic [BA-1:0]    req_addr, addr_q;
  logic [Width-1:0] wdata_q, word_q, rdata_q, load_val, merged;
  logic             unused_addr_hi;

  assign unused_addr_hi = ^addr[31:BA];
  assign accept         = req_valid && req_ready;
  assign req_size       = decode_size(is_store, funct3);

`ifdef LSU_MISALIGN_TRAP_EN
  logic mis_q;
  always_comb begin
    req_addr = addr[BA-1:0];
    trap_hit = (req_size == SZ_H && addr[0]) ||
               (req_size == SZ_W && addr[1:0] != 2'b00);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      mis_q <= 1'b0;
    else if (accept) mis_q <= trap_hit;
  end
  assign misaligned = resp_valid && mis_q;
`else
  // Offending low bits are dropped so the access lands on the aligned lane.
  always_comb begin
    req_addr = addr[BA-1:0];
    trap_hit = 1'b0;
    if (req_size == SZ_H) req_addr[0]   = 1'b0;
    if (req_size == SZ_W) req_addr[1:0] = 2'b00;
  end
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (accept) begin
          if (trap_hit)                         state_nx = S_RESP;
          else if (is_store && req_size == SZ_W) state_nx = S_WR;
          else                                  state_nx = S_RD;  // loads and sub-word RMW
        end
      end
      S_RD:   begin MemRead = 1'b1; state_nx = S_CAP; end
      S_CAP:  state_nx = store_q ? S_WR : S_RESP;
      S_WR:   begin MemWrite = 1'b1; state_nx = S_RESP; end
      S_RESP: begin resp_valid = 1'b1; state_nx = S_IDLE; end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      size_q  <= SZ_W;
      uns_q   <= 1'b0;
      store_q <= 1'b0;
      wdata_q <= '0;
      word_q  <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        addr_q  <= req_addr;
        size_q  <= req_size;
        uns_q   <= decode_unsigned(is_store, funct3);
        store_q <= is_store;
        wdata_q <= wdata;
      end
      // ReadData is valid in CAP; keep the raw word for RMW, the extended value for loads.
      if (state == S_CAP) begin
        word_q <= ReadData;
        if (!store_q) rdata_q <= load_val;
      end
    end
  end

  lsu_align #(.Width(Width)) u_align (
    .size        (size_q),
    .is_unsigned (uns_q),
    .lane        (addr_q[1:0]),
    .rd_word     (ReadData),
    .old_word    (word_q),
    .wdata       (wdata_q),
    .load_val    (load_val),
    .merged      (merged)
  );

  assign Addr   = addr_q[BA-1:2];
  assign WrData = (state == S_WR) ? merged : '0;
  assign rdata  = rdata_q;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter Width, default 32: data path width; only 32 is supported.
REQ-002 SHALL have parameter AddrBits, default 8: memory word-address width.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  CPU access request.
REQ-006 req_ready  output  1  unit idle and able to accept a request.
REQ-007 is_store  input  1  1 = store, 0 = load.
REQ-008 funct3  input  3  RV32I size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; for stores, 000 SB, 001 SH, 010 SW.
REQ-009 addr  input  32  byte address.
REQ-010 wdata  input  Width  store data, low-aligned.
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 rdata  output  Width  load result, extended; held until the next resp_valid.
REQ-013 misaligned  output  1  qualified by resp_valid; access was not performed.
REQ-014 MemWrite, MemRead  output  1 each  DataMemory controls.
REQ-015 Addr  output  AddrBits  DataMemory word address = addr[AddrBits+1:2].
REQ-016 WrData  output  Width  full-word write data to DataMemory.
REQ-017 ReadData  input  Width  DataMemory output; valid the cycle after MemRead is sampled.

Function
REQ-018 The unit SHALL implement the FSM IDLE, RD, CAP, WR, RESP; req_ready SHALL be 1 only in IDLE.
REQ-019 A request SHALL be accepted on req_valid&&req_ready; addr, funct3, is_store and wdata SHALL be registered at acceptance (cycle T).
REQ-020 Loads: IDLE->RD (T+1, MemRead=1)->CAP (T+2, capture ReadData)->RESP (T+3, resp_valid=1)->IDLE.
REQ-021 SW: IDLE->WR (T+1, MemWrite=1, WrData=wdata)->RESP (T+2).
REQ-022 SB/SH: read-modify-write IDLE->RD->CAP->WR (T+3, WrData = captured word with only the addressed byte/halfword lane replaced)->RESP (T+4).
REQ-023 Lane select: byte lane = addr[1:0], halfword lane = addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through.
REQ-024 MemRead and MemWrite SHALL never be asserted in the same cycle and SHALL be 0 outside RD/WR.
REQ-025 Unsupported funct3 codes SHALL be treated as LW/SW.
REQ-026 req_valid during a non-IDLE state SHALL be ignored (not queued).
REQ-027 Addresses beyond 2^(AddrBits+2) bytes SHALL wrap (upper bits discarded).

Reset
REQ-028 On rst_n low: state=IDLE, req_ready=1, resp_valid=0, misaligned=0, rdata=0, MemRead=0, MemWrite=0, Addr=0, WrData=0, immediately and asynchronously.
REQ-029 Reset mid-operation SHALL abandon the access with no resp_valid; a write already sampled by memory is not undone.

Configuration
REQ-030 Macro LSU_MISALIGN_TRAP_EN defined: halfword with addr[0]=1 or word with addr[1:0]!=0 SHALL go IDLE->RESP (T+1) with misaligned=1, no memory access, rdata unchanged.
REQ-031 Macro undefined: misaligned tied 0; offending low address bits forced to 0 and the access performed normally.

Structure
REQ-032 Package lsu_pkg SHALL hold funct3 constants and FSM state encodings.
REQ-033 Combinational sub-module lsu_align SHALL perform lane extraction/extension and store-lane merge.

Verification
REQ-034 SW addr=0x10 wdata=0xAAAAAAAA, then LW 0x10 -> MemWrite at T+1 with Addr=4; load resp_valid at T+3 with rdata=0xAAAAAAAA.
REQ-035 Memory word 4=0x12345678; SB addr=0x11 wdata=0xFF -> WrData=0x1234FF78 at T+3, resp_valid at T+4.
REQ-036 Word 4=0x0000F080; LB 0x10 -> 0xFFFFFF80; LBU 0x10 -> 0x00000080; LH 0x10 -> 0xFFFFF080.
REQ-037 With LSU_MISALIGN_TRAP_EN, LW addr=0x12 -> resp_valid and misaligned=1 at T+1, MemRead/MemWrite never asserted; without it, same request reads word 4.
REQ-038 rst_n pulsed low in CAP of a load -> all outputs at reset values asynchronously, no resp_valid, next request accepted normally.
